// File: rtl/pci_pkg.sv
// Shared PCI configuration definitions: completion status codes and the
// dword offsets of the configuration registers used by the host software.
package pci_pkg;

  // Completion status reported with every configuration response.
  typedef enum logic [1:0] {
    CFG_ST_OK      = 2'd0,
    CFG_ST_WERR    = 2'd1,
    CFG_ST_TIMEOUT = 2'd2
  } cfg_status_t;

  // Dword indices into configuration space.
  localparam logic [5:0] CFG_VENDOR_DEVICE  = 6'd0;
  localparam logic [5:0] CFG_COMMAND_STATUS = 6'd1;
  localparam logic [5:0] CFG_REV_CLASS      = 6'd2;
  localparam logic [5:0] CFG_BAR0           = 6'd4;

endpackage

// File: rtl/pci_cfg_master.sv
// PCI configuration master: accepts one host request at a time, drives it onto
// the responder config port, waits for completion, lets the responder drop
// cfg_done, then returns one response.
// Optional feature: define PCI_CFG_MASTER_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES cycles without cfg_done (response data all ones, TIMEOUT).
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. A valid
// side holds its payload stable until the transfer; ready never depends on the
// same cycle's valid of the other channel.
module pci_cfg_master
  import pci_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_iswrite,
  input  logic [5:0]  req_offset,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output cfg_status_t rsp_status,
  output logic        cfg_enable,
  output logic        cfg_iswrite,
  output logic [5:0]  cfg_offset,
  output logic [31:0] cfg_write_val,
  output logic [3:0]  cfg_be,
  input  logic [31:0] cfg_read_val,
  input  logic        cfg_done,
  input  logic        cfg_w_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        cap_en;
  logic [31:0] cap_rdata;
  cfg_status_t cap_status;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("pci_cfg_master: TIMEOUT_CYCLES must be in 2..255");
  end

`ifdef PCI_CFG_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;
`endif

  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, handshake/strobe outputs and completion capture selection.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    cfg_enable = 1'b0;
    rsp_valid  = 1'b0;
    cap_en     = 1'b0;
    cap_rdata  = 32'h0;
    cap_status = CFG_ST_OK;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        cfg_enable = 1'b1;
        if (cfg_done) begin
          cap_en     = 1'b1;
          cap_rdata  = cfg_iswrite ? 32'h0 : cfg_read_val;
          cap_status = cfg_w_err ? CFG_ST_WERR : CFG_ST_OK;
          state_next = RELEASE;
        end
`ifdef PCI_CFG_MASTER_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          cap_en     = 1'b1;
          cap_rdata  = 32'hFFFF_FFFF;
          cap_status = CFG_ST_TIMEOUT;
          state_next = RELEASE;
        end
`endif
      end
      RELEASE: begin
        // Wait for the responder to drop done so it is not mistaken for the
        // completion of the next request.
        if (!cfg_done) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture on handshake; fields stay on the config port afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_iswrite   <= 1'b0;
      cfg_offset    <= 6'h0;
      cfg_write_val <= 32'h0;
      cfg_be        <= 4'h0;
    end else if (state == IDLE && req_valid) begin
      cfg_iswrite   <= req_iswrite;
      cfg_offset    <= req_offset;
      cfg_write_val <= req_wdata;
      cfg_be        <= req_be;
    end
  end

  // Response capture; held stable until the host takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata  <= 32'h0;
      rsp_status <= CFG_ST_OK;
    end else if (cap_en) begin
      rsp_rdata  <= cap_rdata;
      rsp_status <= cap_status;
    end
  end

`ifdef PCI_CFG_MASTER_TIMEOUT_EN
  // Counts ISSUE cycles without done; restarted for every accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 8'h0;
    end else if (state == IDLE && req_valid) begin
      tmo_cnt <= 8'h0;
    end else if (state == ISSUE && !cfg_done) begin
      tmo_cnt <= tmo_cnt + 8'h1;
    end
  end
`endif

endmodule

// File: tb/tb_pci_cfg_master.sv
// Self-checking bench for pci_cfg_master: a behavioural config responder with
// programmable latency, directed scenarios and a randomized transaction loop,
// all checked against a register-level reference model.
`timescale 1ns/1ps
module tb_pci_cfg_master;
  import pci_pkg::*;

  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_iswrite;
  logic [5:0]  req_offset;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  cfg_status_t rsp_status;
  logic        cfg_enable, cfg_iswrite;
  logic [5:0]  cfg_offset;
  logic [31:0] cfg_write_val;
  logic [3:0]  cfg_be;
  logic [31:0] cfg_read_val;
  logic        cfg_done, cfg_w_err;
  logic [1:0]  dbg_state;

  pci_cfg_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_iswrite(req_iswrite),
    .req_offset(req_offset), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status),
    .cfg_enable(cfg_enable), .cfg_iswrite(cfg_iswrite), .cfg_offset(cfg_offset),
    .cfg_write_val(cfg_write_val), .cfg_be(cfg_be),
    .cfg_read_val(cfg_read_val), .cfg_done(cfg_done), .cfg_w_err(cfg_w_err),
    .dbg_state(dbg_state)
  );

  // ---------------- responder (config space device) ----------------
  int          resp_lat;
  bit          resp_never;
  bit          resp_force_werr;
  int          resp_cnt;
  logic [31:0] resp_mem [64];

  function automatic logic [31:0] resp_wmask(logic [5:0] off, logic [3:0] be);
    case (off)
      CFG_COMMAND_STATUS: return 32'h0000_0547;
      CFG_BAR0:           return (be == 4'hF) ? 32'hFFFF_F000 : 32'h0;
      default:            return 32'h0;
    endcase
  endfunction

  // Completes an access resp_lat cycles after enable rises; done falls with enable.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_cnt     <= 0;
      cfg_done     <= 1'b0;
      cfg_w_err    <= 1'b0;
      cfg_read_val <= 32'h0;
      for (int i = 0; i < 64; i++) resp_mem[i] <= 32'h0;
      resp_mem[0] <= 32'h11E8_1234;
      resp_mem[2] <= 32'hFF00_0009;
    end else if (!cfg_enable) begin
      resp_cnt <= 0;
      cfg_done <= 1'b0;
    end else begin
      if (!resp_never && resp_cnt == resp_lat) begin
        cfg_done <= 1'b1;
        if (cfg_iswrite) begin
          cfg_read_val <= $urandom;
          cfg_w_err    <= (cfg_offset == CFG_BAR0) && (cfg_be != 4'hF);
          for (int b = 0; b < 4; b++)
            if (cfg_be[b])
              resp_mem[cfg_offset][8*b +: 8] <=
                (resp_mem[cfg_offset][8*b +: 8] & ~resp_wmask(cfg_offset, cfg_be)[8*b +: 8]) |
                (cfg_write_val[8*b +: 8] & resp_wmask(cfg_offset, cfg_be)[8*b +: 8]);
        end else begin
          cfg_read_val <= resp_mem[cfg_offset];
          cfg_w_err    <= resp_force_werr;
        end
      end
      resp_cnt <= resp_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_cmd, m_bar0;

  function automatic logic [31:0] be_bits(logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic model_reset();
    m_cmd  = 32'h0;
    m_bar0 = 32'h0;
  endtask

  function automatic logic [31:0] model_read(logic [5:0] off);
    case (off)
      CFG_VENDOR_DEVICE:  return 32'h11E8_1234;
      CFG_COMMAND_STATUS: return m_cmd;
      CFG_REV_CLASS:      return 32'hFF00_0009;
      CFG_BAR0:           return m_bar0;
      default:            return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [5:0] off, input logic [31:0] wd,
                             input logic [3:0] be, output cfg_status_t st);
    logic [31:0] m;
    st = CFG_ST_OK;
    if (off == CFG_COMMAND_STATUS) begin
      m = be_bits(be) & 32'h0000_0547;
      m_cmd = (m_cmd & ~m) | (wd & m);
    end else if (off == CFG_BAR0) begin
      if (be == 4'hF) m_bar0 = wd & 32'hFFFF_F000;
      else            st = CFG_ST_WERR;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Runs one request/response; called and returning on a negative clock edge.
  task automatic do_txn(input bit wr, input logic [5:0] off, input logic [31:0] wd,
                        input logic [3:0] be, input int lat, input bit never,
                        input bit fw, input int hold, output logic [31:0] got);
    cfg_status_t st;
    logic [33:0] e;
    logic [31:0] first_data;
    cfg_status_t first_st;
    int w, n, en;
    if (never) begin
      exp_q.push_back({CFG_ST_TIMEOUT, 32'hFFFF_FFFF});
    end else if (wr) begin
      model_write(off, wd, be, st);
      exp_q.push_back({st, 32'h0});
    end else begin
      exp_q.push_back({fw ? CFG_ST_WERR : CFG_ST_OK, model_read(off)});
    end
    resp_lat = lat; resp_never = never; resp_force_werr = fw;
    req_valid = 1'b1; req_iswrite = wr; req_offset = off; req_wdata = wd; req_be = be;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    check("req_ready_wait", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_iswrite = $urandom_range(0, 1); req_offset = 6'($urandom);
    req_wdata = $urandom; req_be = 4'($urandom);
    n = 1; en = 0;
    while (1) begin
      if (cfg_enable) en++;
      if (n == 1) begin
        check("cfg_offset", {26'h0, cfg_offset}, {26'h0, off});
        check("cfg_iswrite", {31'h0, cfg_iswrite}, {31'h0, wr});
      end
      if (rsp_valid || n >= 300) break;
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", {31'h0, rsp_valid}, 32'h1);
    if (never) begin
      check("tmo_enable_cycles", en, TMO);
    end else begin
      check("enable_cycles", en, lat + 2);
      check("rsp_latency", n, lat + 5);
    end
    e = exp_q.pop_front();
    check("rsp_rdata", rsp_rdata, e[31:0]);
    check("rsp_status", {30'h0, rsp_status}, {30'h0, e[33:32]});
    got = rsp_rdata;
    first_data = rsp_rdata; first_st = rsp_status;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("hold_rdata", rsp_rdata, first_data);
      check("hold_status", {30'h0, rsp_status}, {30'h0, first_st});
      check("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_req_ready", {31'h0, req_ready}, 32'h1);
    check("post_rsp_valid", {31'h0, rsp_valid}, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  logic [5:0]  offs [6];
  logic [31:0] got;
  int          seen;

  initial begin
    offs = '{CFG_VENDOR_DEVICE, CFG_COMMAND_STATUS, CFG_REV_CLASS, CFG_BAR0, 6'd5, 6'd63};
    n_checks = 0; n_pass = 0;
    rst = 1'b1;
    req_valid = 1'b0; req_iswrite = 1'b0; req_offset = 6'h0; req_wdata = 32'h0; req_be = 4'h0;
    rsp_ready = 1'b0;
    resp_lat = 0; resp_never = 1'b0; resp_force_werr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_cfg_enable", {31'h0, cfg_enable}, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_status", {30'h0, rsp_status}, {30'h0, CFG_ST_OK});
    check("reset_cfg_offset", {26'h0, cfg_offset}, 32'h0);
    check("reset_cfg_write_val", cfg_write_val, 32'h0);
    rst = 1'b0;
    #1 check("req_ready_after_reset", {31'h0, req_ready}, 32'h1);
    @(negedge clk);

    // Vendor/device read against a zero-wait responder.
    do_txn(1'b0, CFG_VENDOR_DEVICE, 32'h0, 4'hF, 0, 1'b0, 1'b0, 0, got);
    // Command register: enable bus master, read it back.
    do_txn(1'b1, CFG_COMMAND_STATUS, 32'h0000_0006, 4'h1, 0, 1'b0, 1'b0, 0, got);
    do_txn(1'b0, CFG_COMMAND_STATUS, 32'h0, 4'hF, 0, 1'b0, 1'b0, 0, got);
    check("cmd_bus_master_bit", {31'h0, got[2]}, 32'h1);
    // Partial BAR0 write is rejected and leaves BAR0 untouched.
    do_txn(1'b1, CFG_BAR0, 32'hFEDC_0000, 4'h7, 0, 1'b0, 1'b0, 0, got);
    do_txn(1'b0, CFG_BAR0, 32'h0, 4'hF, 0, 1'b0, 1'b0, 0, got);
    // Host back-pressure on the response.
    do_txn(1'b0, CFG_REV_CLASS, 32'h0, 4'hF, 0, 1'b0, 1'b0, 3, got);
    // Read flagged with an error keeps its data.
    do_txn(1'b0, CFG_COMMAND_STATUS, 32'h0, 4'hF, 1, 1'b0, 1'b1, 1, got);
    // Slow responder beyond the timeout window still completes normally
    // unless the timeout feature is built in.
`ifdef PCI_CFG_MASTER_TIMEOUT_EN
    do_txn(1'b0, CFG_VENDOR_DEVICE, 32'h0, 4'hF, 10, 1'b0, 1'b0, 0, got);
    do_txn(1'b0, CFG_VENDOR_DEVICE, 32'h0, 4'hF, 0, 1'b1, 1'b0, 2, got);
`else
    do_txn(1'b0, CFG_VENDOR_DEVICE, 32'h0, 4'hF, 30, 1'b0, 1'b0, 0, got);
`endif

    // Reset while ISSUE is waiting on a responder that never answers.
    resp_never = 1'b1; resp_lat = 0;
    req_valid = 1'b1; req_iswrite = 1'b0; req_offset = CFG_REV_CLASS; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_reset_enable", {31'h0, cfg_enable}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_cfg_enable", {31'h0, cfg_enable}, 32'h0);
    check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("midrst_rsp_rdata", rsp_rdata, 32'h0);
    check("midrst_cfg_offset", {26'h0, cfg_offset}, 32'h0);
    @(negedge clk);
    rst = 1'b0; resp_never = 1'b0;
    model_reset();
    #1 check("req_ready_after_midrst", {31'h0, req_ready}, 32'h1);
    seen = 0;
    repeat (8) begin @(negedge clk); if (rsp_valid) seen++; end
    check("no_rsp_after_abort", seen, 0);
    do_txn(1'b0, CFG_REV_CLASS, 32'h0, 4'hF, 0, 1'b0, 1'b0, 0, got);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      do_txn(1'($urandom_range(0, 1)), offs[$urandom_range(0, 5)], $urandom,
             4'($urandom), $urandom_range(0, 6), 1'b0, ($urandom_range(0, 7) == 0),
             $urandom_range(0, 3), got);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pci_cfg_master.md
PCI_CFG_MASTER -- requirements
Module: pci_cfg_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, cycles to wait for cfg_done before aborting (legal 2..255).
REQ-002 clk  input  1  single clock; all logic is rising-edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  a host configuration request is present.
REQ-005 req_ready  output  1  block accepts a request; transfer occurs on req_valid && req_ready.
REQ-006 req_iswrite  input  1  1 = write, 0 = read.
REQ-007 req_offset  input  6  dword index into configuration space.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_be  input  4  byte enables.
REQ-010 rsp_valid  output  1  response is available.
REQ-011 rsp_ready  input  1  host accepts the response.
REQ-012 rsp_rdata  output  32  read data.
REQ-013 rsp_status  output  2  pci_pkg::cfg_status_t value: OK, WERR, or TIMEOUT.
REQ-014 cfg_enable, cfg_iswrite  output  1 each  drive the responder-side config port.
REQ-015 cfg_offset  output  6; cfg_write_val  output  32; cfg_be  output  4.
REQ-016 cfg_read_val  input  32; cfg_done  input  1; cfg_w_err  input  1  responder returns.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, RELEASE and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; on handshake, the iswrite/offset/wdata/be fields SHALL be registered and the FSM SHALL move to ISSUE.
REQ-019 cfg_enable SHALL be 1 only in ISSUE; the cfg_iswrite/offset/write_val/be outputs SHALL hold the registered request from ISSUE through RELEASE.
REQ-020 In ISSUE with cfg_done=1: capture cfg_read_val (reads) or 32'h0 (writes) and capture status WERR if cfg_w_err=1, else OK; then go to RELEASE.
REQ-021 RELEASE SHALL hold cfg_enable=0 until cfg_done=0 is sampled, then go to RESP; this prevents a stale done from being taken as the next completion.
REQ-022 RESP SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_status until rsp_ready=1, then go to IDLE; there is no same-cycle re-accept.
REQ-023 Against a zero-wait responder, rsp_valid SHALL rise in the 5th cycle after the request handshake cycle.
REQ-024 A read with cfg_w_err=1 SHALL still report WERR, with the captured read data.
REQ-025 rsp_valid=0 in all states other than RESP; request inputs SHALL be ignored outside IDLE.

Reset
REQ-026 On rst=1, asynchronously: state to IDLE, cfg_enable=0, rsp_valid=0, rsp_rdata=0, rsp_status=OK, all cfg_* outputs 0, timeout counter 0.
REQ-027 A reset asserted mid-ISSUE or mid-RESP SHALL abandon the transaction with no response.
REQ-028 After rst deasserts, req_ready SHALL be 1 on the first clock.

Configuration
REQ-029 Macro PCI_CFG_MASTER_TIMEOUT_EN SHALL gate the timeout feature.
- Defined: a counter SHALL increment each ISSUE cycle with cfg_done=0.
- On reaching TIMEOUT_CYCLES, the block SHALL go to RELEASE with rsp_rdata=32'hFFFFFFFF and status TIMEOUT.
- The counter SHALL clear on entry to ISSUE.
REQ-030 Without PCI_CFG_MASTER_TIMEOUT_EN: no counter SHALL exist, ISSUE SHALL wait indefinitely, and TIMEOUT SHALL never be reported.

Structure
REQ-031 pci_pkg SHALL hold cfg_status_t (2-bit enum: CFG_ST_OK=0, CFG_ST_WERR=1, CFG_ST_TIMEOUT=2) and the existing cfg register offset constants.
REQ-032 The FSM state enum SHALL be local to the module.
REQ-033 The block SHALL be a single module with no sub-module; the timeout counter is inline under the macro.

Verification
REQ-034 Read offset CFG_VENDOR_DEVICE, be=4'hF, against pci_cfg -> rsp_rdata=32'h11E81234, status OK, rsp_valid in cycle 5 after handshake.
REQ-035 Write CFG_COMMAND_STATUS, wdata=32'h00000006, be=4'h1, then read it back -> read bit 2 (bus master)=1, status OK for both.
REQ-036 Write CFG_BAR0, wdata=32'hFEDC0000, be=4'h7 -> status WERR; a following BAR0 read returns 32'h00000000.
REQ-037 Stub responder that never asserts done, macro defined, TIMEOUT_CYCLES=16 -> cfg_enable high 16 cycles, rsp_rdata=32'hFFFFFFFF, status TIMEOUT.
REQ-038 rsp_ready held 0 for 3 cycles -> response stable and req_ready=0 throughout; handshake on cycle 4 -> req_ready=1 the next cycle.
REQ-039 rst pulsed during ISSUE -> cfg_enable=0 and rsp_valid=0 immediately; no response; the next read of CFG_REV_CLASS returns 32'hFF000009.
